// File: rtl/seg_scan_ctrl.sv
// Scan controller for an 8-digit seven-segment display: double-buffered digit
// storage, slot/guard timing and registered select/nibble/blank outputs for the decoder.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       commit,
  input  logic [7:0] digit_en,
  output logic [3:0] num,
  output logic [2:0] sel,
  output logic       blank,
  output logic       frame_tick,
  output logic       commit_pend,
  output logic       commit_done,
  output logic       o_dbg_state
);

  localparam int DIV_W      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int GRD_W      = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam int GUARD_LAST = (GUARD_CYC > 0) ? GUARD_CYC - 1 : 0;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'(GUARD_LAST);

  typedef enum logic {ST_GUARD = 1'b0, ST_SHOW = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [GRD_W-1:0]   r_guard_cnt;
  logic [2:0]         r_sel;
  logic [3:0]         r_num;
  logic               r_blank;
  logic               r_tick;
  logic               r_done;
  logic               r_pend;
  logic [3:0]         r_shadow [8];
  logic [3:0]         r_active [8];

  logic               w_step;
  logic               w_wrap;
  logic               w_do_commit;
  logic [2:0]         w_sel_nxt;
  logic [3:0]         w_num_nxt;
  logic               w_blank_nxt;

  // Commit protocol: commit is a one-cycle request with no ready; it is latched
  // into r_pend and consumed at the next frame wrap, where commit_done pulses.
  always_comb begin
    w_step      = (r_div_cnt == DIV_LAST);
    w_wrap      = w_step && (r_sel == 3'd7);
    w_do_commit = w_wrap && (r_pend || commit);
    w_sel_nxt   = w_step ? r_sel + 3'd1 : r_sel;
    w_state_nxt = r_state;
    if (w_step) begin
      w_state_nxt = (GUARD_CYC == 0) ? ST_SHOW : ST_GUARD;
    end else if (r_state == ST_GUARD &&
                 (GUARD_CYC == 0 || r_guard_cnt == GRD_LAST)) begin
      w_state_nxt = ST_SHOW;
    end
    // On a committing wrap, look through to shadow so digit 0 shows the new value at once.
    w_num_nxt   = w_do_commit ? r_shadow[w_sel_nxt] : r_active[w_sel_nxt];
    w_blank_nxt = (w_state_nxt == ST_GUARD) || !digit_en[w_sel_nxt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_GUARD;
      r_div_cnt   <= '0;
      r_guard_cnt <= '0;
      r_sel       <= 3'd0;
      r_num       <= 4'd0;
      r_blank     <= 1'b1;
      r_tick      <= 1'b0;
      r_done      <= 1'b0;
      r_pend      <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_shadow[i] <= 4'd0;
        r_active[i] <= 4'd0;
      end
    end else begin
      r_state   <= w_state_nxt;
      r_div_cnt <= w_step ? '0 : r_div_cnt + DIV_W'(1);
      if (w_step) begin
        r_guard_cnt <= '0;
      end else if (r_state == ST_GUARD && r_guard_cnt != GRD_LAST) begin
        r_guard_cnt <= r_guard_cnt + GRD_W'(1);
      end
      r_sel   <= w_sel_nxt;
      r_num   <= w_num_nxt;
      r_blank <= w_blank_nxt;
      r_tick  <= w_wrap;
      r_done  <= w_do_commit;
      r_pend  <= w_do_commit ? 1'b0 : (r_pend || commit);
      if (w_do_commit) begin
        for (int i = 0; i < 8; i++) begin
          r_active[i] <= r_shadow[i];
        end
      end
      if (wr_en) begin
        r_shadow[wr_addr] <= wr_data;
      end
    end
  end

  assign num         = r_num;
  assign sel         = r_sel;
  assign blank       = r_blank;
  assign frame_tick  = r_tick;
  assign commit_pend = r_pend;
  assign commit_done = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with REFRESH_DIV=4, GUARD_CYC=1: scan table,
// commit timing, write/commit collision, digit masking and mid-frame reset.
module tb_seg_scan_ctrl;

  localparam int RDIV = 4;
  localparam int GCYC = 1;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       commit;
  logic [7:0] digit_en;
  logic [3:0] num;
  logic [2:0] sel;
  logic       blank;
  logic       frame_tick;
  logic       commit_pend;
  logic       commit_done;
  logic       dbg_state;

  int         n_checks;
  int         n_pass;
  int         cyc;
  logic [3:0] exp_digits [8];
  logic [7:0] cur_mask;
  logic       pend_m;

  typedef struct {
    int         cyc_at;
    logic [2:0] sel;
    logic       blank;
    logic       tick;
  } scan_vec_t;

  scan_vec_t tab [15];

  seg_scan_ctrl #(.REFRESH_DIV(RDIV), .GUARD_CYC(GCYC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit      (commit),
    .digit_en    (digit_en),
    .num         (num),
    .sel         (sel),
    .blank       (blank),
    .frame_tick  (frame_tick),
    .commit_pend (commit_pend),
    .commit_done (commit_done),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
  endtask

  // scoreboard: expected outputs derived from cycle count since reset release
  task automatic check_cycle(input logic exp_done);
    int s;
    s = (cyc / RDIV) % 8;
    chk("sel", 8'(sel), 8'(s));
    chk("num", 8'(num), 8'(exp_digits[s]));
    chk("blank", 8'(blank), 8'((cyc % RDIV == 0) || !cur_mask[s]));
    chk("frame_tick", 8'(frame_tick), 8'(cyc > 0 && cyc % 32 == 0));
    chk("commit_pend", 8'(commit_pend), 8'(pend_m));
    chk("commit_done", 8'(commit_done), 8'(exp_done));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      check_cycle(1'b0);
    end
  endtask

  task automatic run_to(input int m);
    for (int k = 0; k < 32 && (cyc % 32) != m; k++) begin
      tick();
      check_cycle(1'b0);
    end
  endtask

  initial begin
    tab[0]  = '{1,  3'd0, 1'b0, 1'b0};
    tab[1]  = '{3,  3'd0, 1'b0, 1'b0};
    tab[2]  = '{4,  3'd1, 1'b1, 1'b0};
    tab[3]  = '{5,  3'd1, 1'b0, 1'b0};
    tab[4]  = '{8,  3'd2, 1'b1, 1'b0};
    tab[5]  = '{11, 3'd2, 1'b0, 1'b0};
    tab[6]  = '{12, 3'd3, 1'b1, 1'b0};
    tab[7]  = '{16, 3'd4, 1'b1, 1'b0};
    tab[8]  = '{20, 3'd5, 1'b1, 1'b0};
    tab[9]  = '{24, 3'd6, 1'b1, 1'b0};
    tab[10] = '{28, 3'd7, 1'b1, 1'b0};
    tab[11] = '{31, 3'd7, 1'b0, 1'b0};
    tab[12] = '{32, 3'd0, 1'b1, 1'b1};
    tab[13] = '{33, 3'd0, 1'b0, 1'b0};
    tab[14] = '{36, 3'd1, 1'b1, 1'b0};

    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = 3'd0;
    wr_data  = 4'd0;
    commit   = 1'b0;
    digit_en = 8'hFF;
    cur_mask = 8'hFF;
    pend_m   = 1'b0;
    for (int i = 0; i < 8; i++) exp_digits[i] = 4'd0;

    // reset state
    repeat (2) @(negedge clk);
    check_cycle(1'b0);
    rst_n = 1'b1;
    cyc   = 0;

    // scan timing table
    for (int v = 0; v < 15; v++) begin
      while (cyc < tab[v].cyc_at) tick();
      chk("tab_sel", 8'(sel), 8'(tab[v].sel));
      chk("tab_blank", 8'(blank), 8'(tab[v].blank));
      chk("tab_tick", 8'(frame_tick), 8'(tab[v].tick));
      chk("tab_num", 8'(num), 8'h00);
    end

    // write digits 1..8 then commit once; visible only from the next wrap
    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b1;
      wr_addr = 3'(i);
      wr_data = 4'(i + 1);
      tick();
      check_cycle(1'b0);
    end
    wr_en  = 1'b0;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    pend_m = 1'b1;
    check_cycle(1'b0);
    run_to(31);
    tick();
    for (int i = 0; i < 8; i++) exp_digits[i] = 4'(i + 1);
    pend_m = 1'b0;
    check_cycle(1'b1);
    run(32);

    // shadow write without commit leaves the display untouched
    wr_en   = 1'b1;
    wr_addr = 3'd3;
    wr_data = 4'hA;
    tick();
    check_cycle(1'b0);
    wr_en = 1'b0;
    run(96);

    // commit and write to shadow[0] on the wrap cycle itself
    run_to(31);
    commit  = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 3'd0;
    wr_data = 4'hF;
    tick();
    commit = 1'b0;
    wr_en  = 1'b0;
    exp_digits[3] = 4'hA;
    check_cycle(1'b1);
    run(32);
    // second commit, with a repeated pulse while pending
    run_to(5);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    pend_m = 1'b1;
    check_cycle(1'b0);
    run(1);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    check_cycle(1'b0);
    run_to(31);
    tick();
    exp_digits[0] = 4'hF;
    pend_m = 1'b0;
    check_cycle(1'b1);

    // digit masking
    run_to(31);
    digit_en = 8'hAA;
    tick();
    cur_mask = 8'hAA;
    check_cycle(1'b0);
    run(31);
    run_to(5);
    digit_en = 8'hA8;
    tick();
    cur_mask = 8'hA8;
    check_cycle(1'b0);
    digit_en = 8'hFF;
    tick();
    cur_mask = 8'hFF;
    check_cycle(1'b0);

    // mid-slot reset with a commit pending
    run_to(10);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    pend_m = 1'b1;
    check_cycle(1'b0);
    run_to(22);
    chk("pre_rst_sel", 8'(sel), 8'd5);
    rst_n = 1'b0;
    #1;
    chk("rst_sel", 8'(sel), 8'd0);
    chk("rst_num", 8'(num), 8'd0);
    chk("rst_blank", 8'(blank), 8'd1);
    chk("rst_pend", 8'(commit_pend), 8'd0);
    chk("rst_tick", 8'(frame_tick), 8'd0);
    chk("rst_done", 8'(commit_done), 8'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    cyc    = 0;
    pend_m = 1'b0;
    for (int i = 0; i < 8; i++) exp_digits[i] = 4'd0;
    check_cycle(1'b0);
    run_to(31);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    check_cycle(1'b1);
    run(8);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
